multi_edge_detect: RTL



---
 rtl/multi_edge_detect.sv | 127 ++++++++++++
 1 files changed

// File: rtl/multi_edge_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_edge_detect
// Description : Multi-channel input conditioner for slow asynchronous lines
//               (e.g. I2C SCL/SDA). Each channel has a synchroniser, a
//               persistence filter, registered rise/fall pulses, and a sticky
//               event flag. The flags are OR-ed into a single interrupt.
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous active-high reset
//               sig_in       - raw asynchronous line inputs [NUM_CH]
//               rise_en      - rising edge may set event_flag [NUM_CH]
//               fall_en      - falling edge may set event_flag [NUM_CH]
//               clr          - synchronous clear of event_flag [NUM_CH]
//               level        - filtered, synchronised line level [NUM_CH]
//               rising_edge  - one-cycle pulse on filtered 0->1 [NUM_CH]
//               falling_edge - one-cycle pulse on filtered 1->0 [NUM_CH]
//               event_flag   - sticky edge-event flag [NUM_CH]
//               irq          - OR of all event flags
// Revision    : 1.0 - initial release
// ============================================================================
module multi_edge_detect #(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter bit RESET_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic [NUM_CH-1:0] rise_en,
    input  logic [NUM_CH-1:0] fall_en,
    input  logic [NUM_CH-1:0] clr,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] rising_edge,
    output logic [NUM_CH-1:0] falling_edge,
    output logic [NUM_CH-1:0] event_flag,
    output logic              irq
);

    localparam int                 c_cnt_w   = $clog2(FILTER_LEN + 1);
    // Count value at which one more differing sample accepts the new level.
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);

    logic [NUM_CH-1:0] w_flag_next;
    logic              r_irq;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_cnt_w-1:0]     r_cnt;
            logic                   r_level;
            logic                   r_rise;
            logic                   r_fall;
            logic                   r_flag;
            logic                   w_s;
            logic                   w_accept;
            logic                   w_set;

            assign w_s      = r_sync[SYNC_STAGES-1];
            // The new level is taken on the FILTER_LEN-th consecutive
            // differing sample; any agreeing sample restarts the count.
            assign w_accept = (w_s != r_level) && (r_cnt == c_cnt_max);

            // Synchroniser: bit 0 samples the raw line, top bit is used.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= {SYNC_STAGES{RESET_LEVEL}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in[i]};
                end
            end

            // Persistence filter and edge pulses. The pulse is registered
            // on the same edge as the level so both appear together.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= RESET_LEVEL;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_rise <= w_accept & ~r_level;
                    r_fall <= w_accept &  r_level;
                    if (w_s == r_level) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        r_cnt   <= '0;
                        r_level <= ~r_level;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Set wins over clear so an event arriving with clr is not lost.
            assign w_set          = (r_rise & rise_en[i]) | (r_fall & fall_en[i]);
            assign w_flag_next[i] = w_set | (r_flag & ~clr[i]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_flag <= 1'b0;
                end else begin
                    r_flag <= w_flag_next[i];
                end
            end

            assign level[i]        = r_level;
            assign rising_edge[i]  = r_rise;
            assign falling_edge[i] = r_fall;
            assign event_flag[i]   = r_flag;
        end
    endgenerate

    // Built from the next-state flags so irq moves in step with event_flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_flag_next;
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire
